lbp_histogram: RTL and testbench



---
 rtl/lbp_pkg.sv | 16 +
 rtl/lbp_hist_bank.sv | 48 ++++
 rtl/lbp_histogram.sv | 147 ++++++++++++++
 tb/tb_lbp_histogram.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and FSM state type for the LBP histogram stage.
package lbp_pkg;

  localparam int CNT_W  = 14;
  localparam int NBINS  = 256;
  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;
  localparam int BIN_W  = 8;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } lbp_state_e;

endpackage

// File: rtl/lbp_hist_bank.sv
// Flop-array histogram storage: saturating increment, read mux, clear port.
module lbp_hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = lbp_pkg::CNT_W,
  parameter int NBINS = lbp_pkg::NBINS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [BIN_W-1:0] inc_idx,
  input  logic [BIN_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             clr_en,
  input  logic [BIN_W-1:0] clr_idx
);

  logic [CNT_W-1:0] cnt_q [NBINS];
  logic [CNT_W-1:0] cnt_d [NBINS];

  // Clear wins over increment; the two ports are never active together in use.
  always_comb begin
    for (int i = 0; i < NBINS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (inc_en && !(&cnt_q[inc_idx])) begin
      cnt_d[inc_idx] = cnt_q[inc_idx] + 1'b1;
    end
    if (clr_en) begin
      cnt_d[clr_idx] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBINS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/lbp_histogram.sv
// 256-bin LBP code histogram with clear-on-drain valid/ready readout.
// Optional build macro LBP_HIST_SKIPZERO_EN: zero bins are skipped during the drain.
module lbp_histogram
  import lbp_pkg::*;
#(
  parameter int CNT_W = lbp_pkg::CNT_W,
  parameter int NBINS = lbp_pkg::NBINS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lbp_valid,
  input  logic [BIN_W-1:0]  lbp_data,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic              finish,
  input  logic              restart,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [BIN_W-1:0]  hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              hist_done,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              overrun,
  output logic [ADDR_W-1:0] last_addr
);

  // Handshake: a bin transfers on any rising clk edge where hist_valid and
  // hist_ready are both high; while valid is high and ready low, hist_bin and
  // hist_count hold, and valid never drops before the transfer.

  lbp_state_e        state_q, state_d;
  logic [BIN_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              finish_d_q, finish_d_d;

  logic [CNT_W-1:0]  rd_cnt;
  logic              in_drain;
  logic              bin_live;
  logic              accept;
  logic              advance;
  logic              finish_rise;
  logic              inc_en;

  assign in_drain    = (state_q == DRAIN);
  assign finish_rise = finish & ~finish_d_q;
  assign finish_d_d  = finish;

`ifdef LBP_HIST_SKIPZERO_EN
  assign bin_live = (rd_cnt != '0);
`else
  assign bin_live = 1'b1;
`endif

  assign hist_valid = in_drain & bin_live;
  assign accept     = hist_valid & hist_ready;
  // Empty bins (skip build only) step the pointer without a handshake.
  assign advance    = in_drain & (accept | ~bin_live);
  assign inc_en     = (state_q == ACCUM) & lbp_valid;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    total_d     = total_q;
    overrun_d   = overrun_q;
    last_addr_d = last_addr_q;
    case (state_q)
      ACCUM: begin
        if (lbp_valid) begin
          if (!(&total_q)) begin
            total_d = total_q + 1'b1;
          end
          last_addr_d = lbp_addr;
        end
        if (finish_rise) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
        if (lbp_valid) begin
          overrun_d = 1'b1;
        end
        if (advance) begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == BIN_W'(NBINS - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (lbp_valid) begin
          overrun_d = 1'b1;
        end
        if (restart) begin
          state_d   = ACCUM;
          total_d   = '0;
          overrun_d = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      ptr_q       <= '0;
      total_q     <= '0;
      overrun_q   <= 1'b0;
      last_addr_q <= '0;
      finish_d_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      total_q     <= total_d;
      overrun_q   <= overrun_d;
      last_addr_q <= last_addr_d;
      finish_d_q  <= finish_d_d;
    end
  end

  lbp_hist_bank #(
    .CNT_W (CNT_W),
    .NBINS (NBINS)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (inc_en),
    .inc_idx (lbp_data),
    .rd_idx  (ptr_q),
    .rd_cnt  (rd_cnt),
    .clr_en  (accept),
    .clr_idx (ptr_q)
  );

  // Bin/count read as zero outside the drain so idle outputs match reset.
  assign hist_bin   = in_drain ? ptr_q  : '0;
  assign hist_count = in_drain ? rd_cnt : '0;
  assign hist_done  = (state_q == DONE);
  assign total_cnt  = total_q;
  assign overrun    = overrun_q;
  assign last_addr  = last_addr_q;

endmodule

// File: tb/tb_lbp_histogram.sv
// Directed bench for lbp_histogram with a reference bin model and drain scoreboard.
module tb_lbp_histogram;

  localparam int CNT_W = 14;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              lbp_valid;
  logic [7:0]        lbp_data;
  logic [13:0]       lbp_addr;
  logic              finish;
  logic              restart;
  logic              hist_valid;
  logic              hist_ready;
  logic [7:0]        hist_bin;
  logic [CNT_W-1:0]  hist_count;
  logic              hist_done;
  logic [CNT_W-1:0]  total_cnt;
  logic              overrun;
  logic [13:0]       last_addr;

  lbp_histogram dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .lbp_addr   (lbp_addr),
    .finish     (finish),
    .restart    (restart),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_done  (hist_done),
    .total_cnt  (total_cnt),
    .overrun    (overrun),
    .last_addr  (last_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [8+CNT_W-1:0] exp_q[$];
  int          model_bins [256];
  int          model_total;
  logic [13:0] model_last_addr;
  logic [13:0] addr_ctr;
  int          n_asserts;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_code(input logic [7:0] code);
    if (model_bins[code] < CMAX) model_bins[code]++;
    if (model_total < CMAX) model_total++;
    model_last_addr = addr_ctr;
  endtask

  // driver: one code strobe, returns #1 after the sampling edge
  task automatic send_code(input logic [7:0] code);
    lbp_valid = 1'b1;
    lbp_data  = code;
    lbp_addr  = addr_ctr;
    model_code(code);
    addr_ctr  = addr_ctr + 14'd1;
    @(posedge clk); #1;
    lbp_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    model_total = 0;
    check("restart_done", {31'd0, hist_done}, 32'd0);
    check("restart_overrun", {31'd0, overrun}, 32'd0);
    check("restart_total", {18'd0, total_cnt}, 32'd0);
  endtask

  task automatic fill_expected();
    for (int b = 0; b < 256; b++) begin
`ifdef LBP_HIST_SKIPZERO_EN
      if (model_bins[b] != 0) exp_q.push_back({b[7:0], model_bins[b][CNT_W-1:0]});
`else
      exp_q.push_back({b[7:0], model_bins[b][CNT_W-1:0]});
`endif
      model_bins[b] = 0;
    end
  endtask

  // mode 0: ready high, mode 1: ready 1 on / 2 off.
  // same_code >= 0 strobes that code in the finish-rise cycle; inject drives a stray code mid-drain.
  task automatic run_drain(input int mode, input int same_code, input bit inject);
    int first_cyc;
    int done_cyc;
    bit stalled;
    logic [7:0] st_bin;
    logic [CNT_W-1:0] st_cnt;
    logic [8+CNT_W-1:0] e;
    first_cyc = -1;
    done_cyc  = -1;
    stalled   = 1'b0;
    st_bin    = '0;
    st_cnt    = '0;
    finish    = 1'b1;
    if (same_code >= 0) begin
      lbp_valid = 1'b1;
      lbp_data  = same_code[7:0];
      lbp_addr  = addr_ctr;
      model_code(same_code[7:0]);
      addr_ctr  = addr_ctr + 14'd1;
    end
    fill_expected();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hist_done) begin
        done_cyc = cyc;
        break;
      end
      hist_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (cyc == 1) lbp_valid = 1'b0;
      if (inject && cyc == 5) begin
        lbp_valid = 1'b1;
        lbp_data  = 8'hC0;
      end
      if (inject && cyc == 6) lbp_valid = 1'b0;
      if (stalled && hist_valid) begin
        check("stall_bin", {24'd0, hist_bin}, {24'd0, st_bin});
        check("stall_count", {18'd0, hist_count}, {18'd0, st_cnt});
      end
      if (hist_valid && first_cyc < 0) first_cyc = cyc;
      if (hist_valid && hist_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("drain_bin", {24'd0, hist_bin}, {24'd0, e[8+CNT_W-1:CNT_W]});
          check("drain_count", {18'd0, hist_count}, {18'd0, e[CNT_W-1:0]});
        end
      end
      stalled = hist_valid & ~hist_ready;
      st_bin  = hist_bin;
      st_cnt  = hist_count;
      @(posedge clk); #1;
    end
    lbp_valid  = 1'b0;
    finish     = 1'b0;
    hist_ready = 1'b0;
    check("drain_done", {31'd0, hist_done}, 32'd1);
    check("sb_leftover", exp_q.size(), 32'd0);
    exp_q.delete();
`ifndef LBP_HIST_SKIPZERO_EN
    // First bin appears one edge after finish is sampled.
    check("first_valid_lat", first_cyc, 32'd1);
    if (mode == 0) check("drain_len", done_cyc - first_cyc, 32'd256);
`endif
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    model_total = 0;
    model_last_addr = '0;
    addr_ctr  = 14'd0;
    for (int b = 0; b < 256; b++) model_bins[b] = 0;
    reset = 1'b1;
    lbp_valid = 1'b0; lbp_data = '0; lbp_addr = '0;
    finish = 1'b0; restart = 1'b0; hist_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    check("rst_valid", {31'd0, hist_valid}, 32'd0);
    check("rst_bin", {24'd0, hist_bin}, 32'd0);
    check("rst_count", {18'd0, hist_count}, 32'd0);
    check("rst_done", {31'd0, hist_done}, 32'd0);
    check("rst_total", {18'd0, total_cnt}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_last_addr", {18'd0, last_addr}, 32'd0);

    // Image 1: nine codes with back-to-back repeats
    send_code(8'h00); send_code(8'hFF); send_code(8'hFF);
    send_code(8'h12); send_code(8'h12); send_code(8'h12);
    send_code(8'h80); send_code(8'h80); send_code(8'h01);
    check("img1_total", {18'd0, total_cnt}, 32'd9);
    check("img1_last_addr", {18'd0, last_addr}, {18'd0, model_last_addr});
    run_drain(0, -1, 1'b0);
    check("img1_overrun", {31'd0, overrun}, 32'd0);
    do_restart();

    // Image 2: saturation, drained with 1-on/2-off backpressure
    for (int i = 0; i < CMAX + 5; i++) send_code(8'h55);
    check("sat_total", {18'd0, total_cnt}, CMAX);
    check("sat_model_bin", model_bins[8'h55], CMAX);
    run_drain(1, -1, 1'b0);
    do_restart();

    // Image 3: code in the finish-rise cycle, stray code mid-drain
    send_code(8'h07); send_code(8'hC0);
    check("img3_total", {18'd0, total_cnt}, 32'd2);
    run_drain(0, 8'h34, 1'b1);
    check("img3_overrun", {31'd0, overrun}, 32'd1);
    check("img3_total_final", {18'd0, total_cnt}, 32'd3);
    do_restart();

    // Image 4: reset asserted at bin 100 of the drain
    send_code(8'h64); send_code(8'h64);
    finish = 1'b1; hist_ready = 1'b1;
    begin
      int waited;
      waited = 0;
      while (!(hist_valid && hist_bin == 8'd100) && waited < 400) begin
        @(posedge clk); #1;
        waited++;
      end
      check("reach_bin100", {24'd0, hist_bin}, 32'd100);
    end
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, hist_valid}, 32'd0);
    check("mid_rst_bin", {24'd0, hist_bin}, 32'd0);
    check("mid_rst_count", {18'd0, hist_count}, 32'd0);
    check("mid_rst_done", {31'd0, hist_done}, 32'd0);
    check("mid_rst_total", {18'd0, total_cnt}, 32'd0);
    check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    check("mid_rst_last_addr", {18'd0, last_addr}, 32'd0);
    finish = 1'b0; hist_ready = 1'b0;
    for (int b = 0; b < 256; b++) model_bins[b] = 0;
    model_total = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Image 5: sparse image after reset; bins 3 and 200 only
    send_code(8'd3); send_code(8'd200); send_code(8'd200);
    check("img5_total", {18'd0, total_cnt}, 32'd3);
    run_drain(0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
